// File: rtl/doppler_led_pkg.sv
// Shared constants for the SPI LED frame receiver and its matrix scanner.
package doppler_led_pkg;

  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned LED_ROWS    = 4;
  localparam int unsigned LED_COLS    = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned BITCNT_W    = 5;
  localparam int unsigned ROW_W       = $clog2(LED_ROWS);

  // Bit counter stops here so an over-long transaction stays distinguishable
  localparam logic [BITCNT_W-1:0] BITCNT_SAT = BITCNT_W'(FRAME_BITS + 1);

endpackage

// File: rtl/led_matrix_scan.sv
// Multiplexed scan of the 4x4 LED matrix.
// Ports:
//   clk, resetn     - clock, asynchronous active-low reset
//   frame[15:0]     - committed frame; bit 4*r+c = row r, column c
//   aled[3:0]       - one-hot anode row select
//   kled_tri[3:0]   - cathode output-enable per column, 1 = drive
// The display buffer only reloads on the 3->0 row wrap, so a frame is never
// shown partially.
module led_matrix_scan
  import doppler_led_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W   = 16,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [FRAME_BITS-1:0] frame,
  output logic [LED_ROWS-1:0]   aled,
  output logic [LED_COLS-1:0]   kled_tri
);

  logic [SCAN_DIV_W-1:0] r_dwell;
  logic [ROW_W-1:0]      r_row;
  logic [FRAME_BITS-1:0] r_display;
  logic [LED_ROWS-1:0]   r_aled;
  logic [LED_COLS-1:0]   r_kled;

  logic                  w_wrap;
  logic [SCAN_DIV_W-1:0] w_dwell_nxt;
  logic [ROW_W-1:0]      w_row_nxt;
  logic [FRAME_BITS-1:0] w_disp_nxt;
  logic [LED_COLS-1:0]   w_kled_nxt;

  // Outputs are registered from next-state values so they line up with the
  // counters they describe (dwell 0 is the first blanked cycle of a row).
  always_comb begin
    w_wrap      = &r_dwell;
    w_dwell_nxt = r_dwell + 1'b1;
    w_row_nxt   = w_wrap ? r_row + 1'b1 : r_row;
    w_disp_nxt  = (w_wrap && (r_row == ROW_W'(LED_ROWS - 1))) ? frame : r_display;
    w_kled_nxt  = '0;
    if (w_dwell_nxt >= SCAN_DIV_W'(BLANK_CYCLES))
      w_kled_nxt = w_disp_nxt[{w_row_nxt, 2'b00} +: LED_COLS];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dwell   <= '0;
      r_row     <= '0;
      r_display <= '0;
      r_aled    <= LED_ROWS'(1);
      r_kled    <= '0;
    end else begin
      r_dwell   <= w_dwell_nxt;
      r_row     <= w_row_nxt;
      r_display <= w_disp_nxt;
      r_aled    <= LED_ROWS'(1) << w_row_nxt;
      r_kled    <= w_kled_nxt;
    end
  end

  assign aled     = r_aled;
  assign kled_tri = r_kled;

endmodule

// File: rtl/spi_led_frame_rx.sv
// SPI mode-0 write-only responder receiving 16-bit LED frames, MSB first.
// Ports:
//   clk, resetn           - 48 MHz clock, asynchronous active-low reset
//   cfg_cs/cfg_si/cfg_sck - SPI pins, asynchronous to clk (SCK <= clk/8)
//   kled_tri, aled        - LED matrix cathode enables / anode row select
//   frame                 - last committed frame
//   frame_valid           - one-cycle pulse on a 16-bit commit
//   rx_err                - one-cycle pulse when CS rises after 1..15 or >16 bits
module spi_led_frame_rx
  import doppler_led_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W   = 16,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_cs,
  input  logic                  cfg_si,
  input  logic                  cfg_sck,
  output logic [LED_COLS-1:0]   kled_tri,
  output logic [LED_ROWS-1:0]   aled,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  rx_err
);

  logic [SYNC_STAGES-1:0] r_cs_sync, r_si_sync, r_sck_sync;
  logic                   r_cs_hist, r_sck_hist;
  logic                   r_cs_rise, r_cs_fall, r_sck_rise, r_si_d;
  logic [BITCNT_W-1:0]    r_bit_cnt;
  logic [FRAME_BITS-1:0]  r_shift, r_frame;
  logic                   r_frame_valid, r_rx_err;

  logic w_cs_s, w_si_s, w_sck_s;

  assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
  assign w_si_s  = r_si_sync[SYNC_STAGES-1];
  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];

  // Edges are registered together with SI so the sample bit stays aligned
  // with the SCK edge that qualifies it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cs_sync  <= '1;
      r_si_sync  <= '0;
      r_sck_sync <= '0;
      r_cs_hist  <= 1'b1;
      r_sck_hist <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_sck_rise <= 1'b0;
      r_si_d     <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cfg_cs};
      r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], cfg_si};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], cfg_sck};
      r_cs_hist  <= w_cs_s;
      r_sck_hist <= w_sck_s;
      r_cs_rise  <= w_cs_s & ~r_cs_hist;
      r_cs_fall  <= ~w_cs_s & r_cs_hist;
      r_sck_rise <= w_sck_s & ~r_sck_hist & ~w_cs_s;
      r_si_d     <= w_si_s;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_rx_err      <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_rx_err      <= 1'b0;
      if (r_cs_fall) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (r_sck_rise) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], r_si_d};
        if (r_bit_cnt != BITCNT_SAT)
          r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_cs_rise) begin
        if (r_bit_cnt == BITCNT_W'(FRAME_BITS)) begin
          r_frame       <= r_shift;
          r_frame_valid <= 1'b1;
        end else if (r_bit_cnt != '0) begin
          r_rx_err <= 1'b1;
        end
      end
    end
  end

  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign rx_err      = r_rx_err;

  led_matrix_scan #(
    .SCAN_DIV_W  (SCAN_DIV_W),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .frame   (r_frame),
    .aled    (aled),
    .kled_tri(kled_tri)
  );

endmodule

// File: tb/tb_spi_led_frame_rx.sv
module tb_spi_led_frame_rx;

  localparam int SDW   = 4;
  localparam int BLANK = 2;
  localparam int DWELL = 1 << SDW;
  localparam int SCAN  = 4 * DWELL;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_cs = 1'b1;
  logic        cfg_si = 1'b0;
  logic        cfg_sck = 1'b0;
  logic [3:0]  kled_tri;
  logic [3:0]  aled;
  logic [15:0] frame;
  logic        frame_valid;
  logic        rx_err;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [15:0] exp_frame = 16'h0000;

  spi_led_frame_rx #(.SCAN_DIV_W(SDW), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .resetn(resetn), .cfg_cs(cfg_cs), .cfg_si(cfg_si), .cfg_sck(cfg_sck),
    .kled_tri(kled_tri), .aled(aled), .frame(frame), .frame_valid(frame_valid), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) n_valid++;
    if (rx_err === 1'b1) n_err++;
  end

  // Drive n bits of data MSB first at SCK = clk/8; optionally raise CS after.
  task automatic send_bits(input logic [31:0] data, input int n, input bit raise);
    @(negedge clk); cfg_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      cfg_si = data[n-1-i]; cfg_sck = 1'b0;
      repeat (4) @(negedge clk);
      cfg_sck = 1'b1;
      repeat (4) @(negedge clk);
    end
    cfg_sck = 1'b0;
    repeat (8) @(negedge clk);
    if (raise) cfg_cs = 1'b1;
  endtask

  // Leaves time at #1 after the posedge where the first cycle of row 0 shows.
  task automatic wait_wrap;
    logic [3:0] prev;
    bit found;
    found = 0;
    prev = aled;
    for (int i = 0; i < 3 * SCAN && !found; i++) begin
      @(posedge clk); #1;
      if (prev == 4'b1000 && aled == 4'b0001) found = 1;
      prev = aled;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_wrap: no 3->0 row wrap seen within %0d cycles", 3 * SCAN);
    end
  endtask

  // Reference: cycle c of a scan shows row c/DWELL; first BLANK cycles of a row dark.
  task automatic check_scan(input logic [15:0] f, input string tag);
    int row, ph;
    logic [3:0] ea, ek;
    for (int c = 0; c < SCAN; c++) begin
      row = c / DWELL;
      ph  = c % DWELL;
      ea  = 4'(1 << row);
      ek  = (ph < BLANK) ? 4'h0 : 4'((f >> (4 * row)) & 16'hF);
      checks++;
      if (aled !== ea || kled_tri !== ek) begin
        errors++;
        $display("FAIL %s cyc=%0d: aled=%b kled_tri=%b, expected aled=%b kled_tri=%b",
                 tag, c, aled, kled_tri, ea, ek);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (aled !== 4'b0001 || kled_tri !== 4'b0000 || frame !== 16'h0000 ||
        frame_valid !== 1'b0 || rx_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: aled=%b kled=%b frame=%h v=%b e=%b, expected 0001 0000 0000 0 0",
               aled, kled_tri, frame, frame_valid, rx_err);
    end
    @(negedge clk); resetn = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (n_valid !== 0 || n_err !== 0 || frame !== 16'h0000) begin
      errors++;
      $display("FAIL reset_idle: valid=%0d err=%0d frame=%h, expected 0 0 0000", n_valid, n_err, frame);
    end
  endtask

  task automatic test_single;
    int v0;
    v0 = n_valid;
    send_bits(32'hA5C3, 16, 0);
    @(negedge clk); cfg_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (frame_valid !== 1'b0 || frame !== 16'h0000) begin
      errors++;
      $display("FAIL latency_early: valid=%b frame=%h at 3 cycles, expected 0 0000", frame_valid, frame);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_valid !== 1'b1 || frame !== 16'hA5C3) begin
      errors++;
      $display("FAIL latency_commit: valid=%b frame=%h at 4 cycles, expected 1 a5c3", frame_valid, frame);
    end
    @(posedge clk); #1;
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: valid=%b one cycle after commit, expected 0", frame_valid);
    end
    repeat (10) @(posedge clk);
    checks++;
    if (n_valid - v0 !== 1 || n_err !== 0) begin
      errors++;
      $display("FAIL single_pulse: valid_pulses=%0d err=%0d, expected 1 0", n_valid - v0, n_err);
    end
    exp_frame = 16'hA5C3;
  endtask

  task automatic test_display;
    wait_wrap();
    check_scan(16'hA5C3, "display_a5c3");
  endtask

  task automatic test_short_long;
    int lens [3] = '{12, 20, 0};
    int v0, e0;
    for (int k = 0; k < 3; k++) begin
      v0 = n_valid; e0 = n_err;
      send_bits(32'hFFFF_F0F0, lens[k], 1);
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (n_err - e0 !== (lens[k] != 0 ? 1 : 0) || n_valid !== v0 || frame !== exp_frame) begin
        errors++;
        $display("FAIL len_%0d: err_pulses=%0d valid_pulses=%0d frame=%h, expected %0d 0 %h",
                 lens[k], n_err - e0, n_valid - v0, frame, (lens[k] != 0 ? 1 : 0), exp_frame);
      end
    end
  endtask

  task automatic test_timed_commit;
    int v0;
    v0 = n_valid;
    send_bits(32'hFFFF, 16, 0);
    wait_wrap();
    repeat (SCAN - 4) @(posedge clk);
    @(negedge clk); cfg_cs = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (frame !== 16'hFFFF || frame_valid !== 1'b1 || aled !== 4'b0001) begin
      errors++;
      $display("FAIL timed_commit: frame=%h valid=%b aled=%b, expected ffff 1 0001", frame, frame_valid, aled);
    end
    check_scan(16'hA5C3, "timed_old");
    check_scan(16'hFFFF, "timed_new");
    checks++;
    if (n_valid - v0 !== 1) begin
      errors++;
      $display("FAIL timed_pulse: valid_pulses=%0d, expected 1", n_valid - v0);
    end
    exp_frame = 16'hFFFF;
  endtask

  task automatic test_random;
    int n, v0, e0, ev, ee;
    logic [31:0] d;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, 20);
      if ($urandom_range(0, 1) == 1) n = 16;
      d = $urandom;
      v0 = n_valid; e0 = n_err;
      send_bits(d, n, 1);
      repeat (8 + $urandom_range(0, 6)) @(posedge clk);
      #1;
      ev = (n == 16) ? 1 : 0;
      ee = (n != 16 && n != 0) ? 1 : 0;
      if (n == 16) exp_frame = d[15:0];
      checks++;
      if (frame !== exp_frame || n_valid - v0 !== ev || n_err - e0 !== ee) begin
        errors++;
        $display("FAIL random_%0d n=%0d: frame=%h valid=%0d err=%0d, expected %h %0d %0d",
                 k, n, frame, n_valid - v0, n_err - e0, exp_frame, ev, ee);
      end
    end
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    send_bits(32'h1B5, 9, 0);
    @(negedge clk); resetn = 1'b0; cfg_cs = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    v0 = n_valid; e0 = n_err;
    checks++;
    if (frame !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_frame: frame=%h, expected 0000", frame);
    end
    send_bits(32'h0001, 16, 1);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (frame !== 16'h0001 || n_valid - v0 !== 1 || n_err - e0 !== 0) begin
      errors++;
      $display("FAIL mid_reset_clean: frame=%h valid=%0d err=%0d, expected 0001 1 0",
               frame, n_valid - v0, n_err - e0);
    end
    wait_wrap();
    check_scan(16'h0001, "display_0001");
  endtask

  initial begin
    test_reset();
    test_single();
    test_display();
    test_short_long();
    test_timed_commit();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_led_frame_rx.md
Name: spi_led_frame_rx

Overview:
- SPI write-only responder on the SAMD51→iCE40 link (cfg_cs/cfg_si/cfg_sck), running after configuration.
- Receives 16-bit LED frames and drives the 4x4 LED matrix by multiplexed scan (aled rows, kled_tri cathodes).
- Sits in top between the SPI pins and the kled SB_IO output-enables; replaces free-running blink logic.

Parameters:
- SCAN_DIV_W, 16: row dwell = 2^SCAN_DIV_W clk cycles; 48 MHz gives ~1.37 ms per row.
- BLANK_CYCLES, 8: clk cycles at the start of each row dwell with all cathodes off; must be < 2^SCAN_DIV_W.

Ports:
- clk  in  1  48 MHz SB_HFOSC clock.
- resetn  in  1  asynchronous active-low reset.
- cfg_cs  in  1  SPI chip select, active low, asynchronous to clk.
- cfg_si  in  1  SPI data in (MOSI), asynchronous to clk.
- cfg_sck  in  1  SPI clock, mode 0, asynchronous to clk; max frequency clk/8.
- kled_tri  out  4  cathode output-enable per column; 1 = drive.
- aled  out  4  anode row select, one-hot, active high.
- frame  out  16  last committed frame; bit 4*r+c = LED at row r, column c.
- frame_valid  out  1  one-cycle pulse when frame commits.
- rx_err  out  1  one-cycle pulse when a transaction ends with a bit count other than 16 and other than 0.

Behaviour:
- Reset, asynchronous, while resetn low:
  - frame = 16'h0000, display buffer = 0.
  - frame_valid = 0, rx_err = 0.
  - bit counter = 0, shift register = 0.
  - row = 0, aled = 4'b0001, kled_tri = 4'b0000, dwell counter = 0.
- Input synchronisation:
  - cfg_cs, cfg_si and cfg_sck each pass through 2 clk flops, then one more history flop for edge detection.
  - SI is taken from the same pipeline stage as the detected SCK edge.
- Receive:
  - Mode 0, MSB first.
  - On a synchronised SCK rising edge while CS is low: shift = {shift[14:0], si}; bit_cnt increments, saturating at 17.
  - SCK edges while CS is high are ignored.
  - Synchronised CS falling edge: bit_cnt = 0, shift register cleared.
- Commit, on synchronised CS rising edge:
  - bit_cnt == 16: frame <= shift, frame_valid = 1 for exactly one cycle.
  - bit_cnt == 0: ignored, no pulse.
  - Any other count (1..15, or overflow 17): frame unchanged, rx_err = 1 for one cycle.
- Latency: frame/frame_valid update 4 clk cycles after the cfg_cs pin rises (2 sync + 1 edge + 1 register).
- Reset mid-transaction: partial data discarded; after release, reception restarts only on the next CS falling edge.
  - If CS is already low at release, SCK edges still shift, but that transaction errors unless exactly 16 bits follow.
- Scan:
  - dwell counter is SCAN_DIV_W bits; row advances 0→1→2→3→0 when the counter wraps.
  - aled = 1 << row.
  - kled_tri = 0 during the first BLANK_CYCLES of each dwell; otherwise display[4*row+3 : 4*row].
- Double buffering:
  - display <= frame only on the cycle row wraps 3→0, so a frame is never shown partially.
  - If commit and the 3→0 wrap occur on the same cycle, display takes the old frame; the new frame appears at the next wrap.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package doppler_led_pkg:
  - FRAME_BITS = 16, LED_ROWS = 4, LED_COLS = 4.
  - SYNC_STAGES = 2, BITCNT_W = 5.
- Sub-module led_matrix_scan (clk, resetn, frame, aled, kled_tri) holds the dwell counter, row counter, blanking and display buffer.
- The top level keeps the synchroniser, shifter and commit logic.

Test Plan (bench uses SCAN_DIV_W = 4, BLANK_CYCLES = 2, SCK = clk/8):
- Reset: hold resetn low, then release → aled = 0001, kled_tri = 0000, frame = 0000, no pulses for 100 cycles with CS high.
- Send 16'hA5C3 in one CS window → frame = A5C3 and a single frame_valid pulse 4 cycles after the CS pin rises.
- Display of A5C3, after the next 3→0 wrap:
  - row0: aled = 0001, kled_tri = 0011.
  - row1: aled = 0010, kled_tri = 1100.
  - row2: aled = 0100, kled_tri = 0101.
  - row3: aled = 1000, kled_tri = 1010.
  - Each row has kled_tri = 0000 for the first 2 cycles of its dwell.
- Short and long transactions:
  - Send 12 bits → rx_err pulse, frame stays A5C3.
  - Send 20 bits → rx_err pulse, frame unchanged.
  - CS low then high with no SCK → no pulses.
- Timed commit: commit 16'hFFFF on the exact cycle of the 3→0 wrap → display remains the old frame for one full scan, then all kled_tri bits are 1 outside blanking.
- Reset after 9 bits received, then a clean 16-bit 16'h0001 → frame = 0001, no rx_err, row0 kled_tri = 0001.
